// File: rtl/ks_adder_pipe.sv
// ks_adder_pipe -- pipelined Kogge-Stone parallel-prefix adder.
//
// This adder takes one operand pair per cycle on a valid/ready stream. It
// returns sum, carry-out, signed overflow and the tag that came in with the
// beat. The prefix tree is split into L = clog2(WIDTH) levels, and each
// level has its own register. The full latency is L + 2 cycles: one input
// register, L prefix registers, and one output register. The whole pipe
// stalls as a single unit whenever the output is held.
//
// Optional feature: define KS_SUB_EN to honour 'sub'. When 'sub' is set,
// the block computes A + ~B + 1 and ignores cin. Without the macro, 'sub'
// is ignored and no inversion logic is built.
//
// Ports:
//   clk, rst_n       clock (rising edge) and asynchronous active-low reset
//   in_valid/ready   input handshake; in_ready = out_ready | ~out_valid
//   a, b, cin        operands and carry-in
//   sub              subtract request (only with KS_SUB_EN)
//   tag_in           opaque sideband tag travelling with the beat
//   out_valid/ready  output handshake
//   sum, cout, ovf   result, MSB carry-out (no-borrow on subtract), overflow
//   tag_out          tag of the presented result
module ks_adder_pipe #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [TAG_W-1:0] tag_out
);

    localparam int L = $clog2(WIDTH);

    // One prefix level: generate combine over distance 'span'.
    // Bits below span already hold their final group value.
    function automatic logic [WIDTH-1:0] level_g(input logic [WIDTH-1:0] g,
                                                 input logic [WIDTH-1:0] p,
                                                 input int               span);
        logic [WIDTH-1:0] r;
        r = g;
        for (int i = 0; i < WIDTH; i++) begin
            if (i >= span) r[i] = g[i] | (p[i] & g[i-span]);
        end
        return r;
    endfunction

    // One prefix level: propagate combine over distance 'span'.
    function automatic logic [WIDTH-1:0] level_p(input logic [WIDTH-1:0] p,
                                                 input int               span);
        logic [WIDTH-1:0] r;
        r = p;
        for (int i = 0; i < WIDTH; i++) begin
            if (i >= span) r[i] = p[i] & p[i-span];
        end
        return r;
    endfunction

    // Global stall: the pipe moves only when the output slot can be
    // emptied or is already empty. There is no path from in_valid.
    logic adv;
    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;

    logic [WIDTH-1:0] b_eff;
    logic             c0_in;
`ifdef KS_SUB_EN
    assign b_eff = sub ? ~b : b;
    assign c0_in = sub | cin;
`else
    logic sub_unused;
    assign sub_unused = sub;
    assign b_eff      = b;
    assign c0_in      = cin;
`endif

    // Carry-in is folded into bit 0's generate. It then acts as
    // generate bit -1, and every group term reaching bit 0 picks it up.
    logic [WIDTH-1:0] p_in;
    logic [WIDTH-1:0] g_in;
    always_comb begin
        p_in    = a ^ b_eff;
        g_in    = a & b_eff;
        g_in[0] = g_in[0] | (p_in[0] & c0_in);
    end

    // Index 0 is the input register (S0). Index k is the register after
    // prefix level k-1 (S1..SL).
    logic [WIDTH-1:0] g_st    [0:L];
    logic [WIDTH-1:0] p_st    [0:L];
    logic [WIDTH-1:0] psum_st [0:L];
    logic             c0_st   [0:L];
    logic [TAG_W-1:0] tag_st  [0:L];
    logic             vld_st  [0:L];

    // ---- S0 .. SL: datapath registers, no reset ----
    always_ff @(posedge clk) begin
        if (adv) begin
            g_st[0]    <= g_in;
            p_st[0]    <= p_in;
            psum_st[0] <= p_in;
            c0_st[0]   <= c0_in;
            tag_st[0]  <= tag_in;
            for (int k = 1; k <= L; k++) begin
                g_st[k]    <= level_g(g_st[k-1], p_st[k-1], 1 << (k-1));
                p_st[k]    <= level_p(p_st[k-1], 1 << (k-1));
                psum_st[k] <= psum_st[k-1];
                c0_st[k]   <= c0_st[k-1];
                tag_st[k]  <= tag_st[k-1];
            end
        end
    end

    // ---- valid chain and S(L+1) output register ----
    // The output data is reset so that an idle, freshly reset block
    // presents all-zero results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= L; k++) vld_st[k] <= 1'b0;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            tag_out   <= '0;
        end else if (adv) begin
            vld_st[0] <= in_valid;
            for (int k = 1; k <= L; k++) vld_st[k] <= vld_st[k-1];
            out_valid <= vld_st[L];
            // carry into bit i is the group generate of bits i-1..0;
            // c0 is the carry into bit 0
            sum       <= psum_st[L] ^ {g_st[L][WIDTH-2:0], c0_st[L]};
            cout      <= g_st[L][WIDTH-1];
            ovf       <= g_st[L][WIDTH-1] ^ g_st[L][WIDTH-2];
            tag_out   <= tag_st[L];
        end
    end

endmodule

// File: tb/tb_ks_adder_pipe.sv
module tb_ks_adder_pipe;

`ifdef KS_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 16-bit instance
    logic        iv16 = 0, ir16, or16 = 1, ov16, cin16 = 0, sub16 = 0, co16, of16;
    logic [15:0] a16 = 0, b16 = 0, s16;
    logic [3:0]  ti16 = 0, to16;

    // 4-bit instance
    logic        iv4 = 0, ir4, or4 = 1, ov4, cin4 = 0, sub4 = 0, co4, of4;
    logic [3:0]  a4 = 0, b4 = 0, s4;
    logic [3:0]  ti4 = 0, to4;

    ks_adder_pipe #(.WIDTH(16), .TAG_W(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
        .a(a16), .b(b16), .cin(cin16), .sub(sub16), .tag_in(ti16),
        .out_valid(ov16), .out_ready(or16), .sum(s16), .cout(co16),
        .ovf(of16), .tag_out(to16));

    ks_adder_pipe #(.WIDTH(4), .TAG_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
        .a(a4), .b(b4), .cin(cin4), .sub(sub4), .tag_in(ti4),
        .out_valid(ov4), .out_ready(or4), .sum(s4), .cout(co4),
        .ovf(of4), .tag_out(to4));

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        logic [3:0]  tag;
    } exp_t;

    exp_t q16[$];
    exp_t q4[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   run16 = 0, max_run16 = 0, n_pop16 = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: plain integer addition modulo 2^w.
    // Overflow is judged from the operand and result signs.
    function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                   input logic cin, input logic sub, input logic [3:0] tag);
        exp_t        r;
        logic [16:0] full;
        logic [15:0] mask, bb;
        logic        c;
        mask = 16'((32'd1 << w) - 1);
        bb   = b;
        c    = cin;
        if (SUB_EN && sub) begin
            bb = ~b & mask;
            c  = 1'b1;
        end
        full   = {1'b0, a} + {1'b0, bb} + 17'(c);
        r.sum  = full[15:0] & mask;
        r.cout = full[w];
        r.ovf  = (a[w-1] == bb[w-1]) && (r.sum[w-1] != a[w-1]);
        r.tag  = tag;
        return r;
    endfunction

    // Scoreboards: push accepted beats, pop and compare delivered results.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (iv16 && ir16) q16.push_back(model(16, a16, b16, cin16, sub16, ti16));
            if (ov16 && or16) begin
                n_pop16++;
                run16++;
                if (run16 > max_run16) max_run16 = run16;
                if (q16.size() == 0) check("m16_extra_beat", 32'(q16.size()), 32'd1);
                else begin
                    e = q16.pop_front();
                    check("m16_sum", 32'(s16), 32'(e.sum));
                    check("m16_cout", 32'(co16), 32'(e.cout));
                    check("m16_ovf", 32'(of16), 32'(e.ovf));
                    check("m16_tag", 32'(to16), 32'(e.tag));
                end
            end else run16 = 0;
            if (iv4 && ir4) q4.push_back(model(4, {12'd0, a4}, {12'd0, b4}, cin4, sub4, ti4));
            if (ov4 && or4) begin
                if (q4.size() == 0) check("m4_extra_beat", 32'(q4.size()), 32'd1);
                else begin
                    e = q4.pop_front();
                    check("m4_sum", 32'(s4), 32'(e.sum));
                    check("m4_cout", 32'(co4), 32'(e.cout));
                    check("m4_ovf", 32'(of4), 32'(e.ovf));
                    check("m4_tag", 32'(to4), 32'(e.tag));
                end
            end
        end
    end

    task automatic single16(input logic [15:0] a, input logic [15:0] b, input logic c,
                            input logic s, input logic [3:0] t, input logic [15:0] xs,
                            input logic xc, input logic xo, input string nm);
        int cnt;
        @(posedge clk); #1;
        a16 = a; b16 = b; cin16 = c; sub16 = s; ti16 = t; iv16 = 1; or16 = 1;
        @(posedge clk); #1;
        iv16 = 0;
        cnt  = 1;
        while (!ov16 && cnt < 50) begin @(posedge clk); #1; cnt++; end
        check({nm, "_latency"}, 32'(cnt), 32'd6);
        check({nm, "_sum"}, 32'(s16), 32'(xs));
        check({nm, "_cout"}, 32'(co16), 32'(xc));
        check({nm, "_ovf"}, 32'(of16), 32'(xo));
        check({nm, "_tag"}, 32'(to16), 32'(t));
        @(posedge clk); #1;
    endtask

    task automatic rand16();
        a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
        sub16 = 1'($urandom); ti16 = 4'($urandom);
    endtask

    // Stream n beats; out_ready is dropped for 'slen' cycles from cycle 'sat'.
    task automatic stream16(input int n, input int sat, input int slen);
        int          idx = 0, cyc = 0;
        logic        acc;
        logic [15:0] hs;
        logic [3:0]  ht;
        rand16();
        while (idx < n && cyc < 2000) begin
            or16 = !(cyc >= sat && cyc < sat + slen);
            iv16 = 1;
            #1;
            acc = ir16;
            if (!or16) begin
                check("stall_in_ready", 32'(ir16), 32'd0);
                if (cyc == sat) begin hs = s16; ht = to16; end
                else begin
                    check("stall_sum_held", 32'(s16), 32'(hs));
                    check("stall_tag_held", 32'(to16), 32'(ht));
                end
            end
            @(posedge clk); #1;
            cyc++;
            if (acc) begin idx++; rand16(); end
        end
        iv16 = 0;
        or16 = 1;
    endtask

    task automatic drain16(input string nm);
        int g = 0;
        while ((q16.size() != 0 || ov16) && g < 200) begin @(posedge clk); #1; g++; end
        check(nm, 32'(q16.size()), 32'd0);
    endtask

    initial begin
        int g;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(ov16), 32'd0);
        check("rst_sum", 32'(s16), 32'd0);
        check("rst_cout", 32'(co16), 32'd0);
        check("rst_ovf", 32'(of16), 32'd0);
        check("rst_tag", 32'(to16), 32'd0);
        check("rst_out_valid4", 32'(ov4), 32'd0);
        rst_n = 1;
        #1;
        check("rst_in_ready", 32'(ir16), 32'd1);

        // Directed 16-bit cases
        single16(16'hFFFF, 16'h0001, 0, 0, 4'hA, 16'h0000, 1, 0, "wrap");
        single16(16'h7FFF, 16'h0001, 0, 0, 4'h3, 16'h8000, 0, 1, "posovf");
        single16(16'h8000, 16'h8000, 0, 0, 4'hC, 16'h0000, 1, 1, "negovf");
        single16(16'h1234, 16'h0000, 1, 0, 4'h5, 16'h1235, 0, 0, "cin_only");

        // 4-bit directed: latency 4
        @(posedge clk); #1;
        a4 = 4'hF; b4 = 4'h1; cin4 = 1; ti4 = 4'h9; iv4 = 1;
        @(posedge clk); #1;
        iv4 = 0;
        g   = 1;
        while (!ov4 && g < 50) begin @(posedge clk); #1; g++; end
        check("w4_latency", 32'(g), 32'd4);
        check("w4_sum", 32'(s4), 32'h1);
        check("w4_cout", 32'(co4), 32'd1);
        check("w4_tag", 32'(to4), 32'h9);
        @(posedge clk); #1;

        // 4-bit exhaustive sweep, back to back
        for (int i = 0; i < 512; i++) begin
            a4 = i[3:0]; b4 = i[7:4]; cin4 = i[8]; ti4 = i[3:0] ^ i[7:4]; iv4 = 1;
            @(posedge clk); #1;
        end
        iv4 = 0;
        g   = 0;
        while (q4.size() != 0 && g < 100) begin @(posedge clk); #1; g++; end
        check("w4_sweep_drained", 32'(q4.size()), 32'd0);

        // Back-to-back burst of 20
        max_run16 = 0;
        stream16(20, -1, 0);
        drain16("b2b_drained");
        check("b2b_consecutive", 32'(max_run16), 32'd20);

        // Burst with a 3-cycle output stall
        stream16(16, 8, 3);
        drain16("stall_drained");

`ifdef KS_SUB_EN
        single16(16'h0005, 16'h0007, 0, 1, 4'h6, 16'hFFFE, 0, 0, "sub5m7");
        single16(16'h8000, 16'h0001, 0, 1, 4'h2, 16'h7FFF, 1, 1, "subovf");
`endif

        // Reset while beats are in flight (output held by out_ready=0)
        or16 = 0;
        for (int j = 0; j < 3; j++) begin
            rand16(); iv16 = 1;
            @(posedge clk); #1;
        end
        iv16 = 0;
        repeat (6) @(posedge clk);
        #1;
        check("pre_rst_valid", 32'(ov16), 32'd1);
        #2;
        rst_n = 0;
        #1;
        check("midrst_out_valid", 32'(ov16), 32'd0);
        check("midrst_sum", 32'(s16), 32'd0);
        check("midrst_tag", 32'(to16), 32'd0);
        q16.delete();
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1;
        #1;
        check("post_rst_in_ready", 32'(ir16), 32'd1);
        n_pop16 = 0;
        @(posedge clk); #1;
        stream16(2, -1, 0);
        drain16("post_rst_drained");
        check("post_rst_beats", 32'(n_pop16), 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ks_adder_pipe.md
# ks_adder_pipe

Parametrised, pipelined Kogge-Stone parallel-prefix adder with a valid/ready stream interface, carry-out and signed-overflow flags, and optional subtract mode. It is the width-generic successor to the team's fixed 4-bit Kogge-Stone adder. It is intended for datapaths that need one add per cycle at widths where a single-cycle prefix tree does not close timing. One register level sits after each prefix stage; results emerge in order with fixed latency.

## Interface
Parameters:
- WIDTH, 16: operand width in bits; legal range ≥ 2.
- TAG_W, 4: width of the sideband tag carried alongside each operation; legal range ≥ 1.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in for add.
- sub  input  1  1 = A − B; ignored unless KS_SUB_EN is defined.
- tag_in  input  TAG_W  opaque tag, returned unchanged with the result.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result bits.
- cout  output  1  carry-out of the MSB; equals no-borrow when subtracting.
- ovf  output  1  two's-complement overflow.
- tag_out  output  TAG_W  tag of the presented result.

## Operation
- L = clog2(WIDTH) prefix levels. For prefix level k (k = 0..L-1), span = 2^k.
- Stage S0 (input register): captures p = a ^ b', g = a & b', c0, tag and MSB operand signs.
  - b' = ~b and c0 = 1 when sub is active; otherwise b' = b and c0 = cin.
- Stages S1..SL: one prefix level each. Bit i with i ≥ span computes:
  - G[i] = G[i] | (P[i] & G[i-span])
  - P[i] = P[i] & P[i-span]
  - Bits with i < span pass through unchanged.
  - c0 is folded in as generate bit −1, i.e. G[-1] = c0. Carries into every bit must be correct for any cin.
- Stage S(L+1), output register:
  - sum[i] = p[i] ^ carry_in[i], where carry_in[0] = c0 and carry_in[i] = G[i-1].
  - cout = G[WIDTH-1].
  - ovf = carry into MSB XOR cout.
- Each stage holds a valid bit. Bubbles are not compressed.
- Global stall: adv = out_ready | ~out_valid.
  - in_ready = adv.
  - On adv, every stage loads from its predecessor. S0 loads in_valid & in_ready.
  - With adv low, all stages hold.
- A beat is transferred in when in_valid & in_ready, and out when out_valid & out_ready.
- Results are returned in acceptance order. tag_out always matches the originating tag_in.

## Timing
- Latency: L + 2 cycles from input acceptance to out_valid, with no stall. WIDTH = 16 gives 6; WIDTH = 4 gives 4.
- Throughput: one result per cycle while out_ready is held high.
- in_ready is combinational from out_ready and out_valid only. There is no path from in_valid.
- While out_valid = 1 and out_ready = 0, the outputs sum, cout, ovf and tag_out are stable.
- Reset: all valid bits cleared.
  - out_valid = 0, sum = 0, cout = 0, ovf = 0, tag_out = 0.
  - in_ready = 1 once rst_n is high.
- Reset asserted mid-stream discards all in-flight beats immediately (asynchronously). No partial result is emitted after release.
- Arithmetic is modulo 2^WIDTH. The carry is reported only via cout.

## Configuration
- KS_SUB_EN defined: sub is honoured.
  - A − B is computed as A + ~B + 1, and cin is ignored for that beat.
  - cout = 1 means no borrow.
  - ovf is signed-subtract overflow.
- KS_SUB_EN undefined: sub is ignored, every beat is an add using cin, and no inversion logic is generated.

## Test plan
- WIDTH=16, a=0xFFFF, b=0x0001, cin=0, single beat, out_ready=1 → 6 cycles later: sum=0x0000, cout=1, ovf=0, tag echoed.
- WIDTH=16, a=0x7FFF, b=0x0001, cin=0 → sum=0x8000, cout=0, ovf=1. Then a=0x8000, b=0x8000 → sum=0x0000, cout=1, ovf=1.
- WIDTH=4, a=0xF, b=0x1, cin=1 → sum=0x1, cout=1 after 4 cycles. Also sweep all 512 combinations of a, b and cin against a reference model.
- Back-to-back stream of 20 random beats with out_ready held at 1 → 20 consecutive out_valid cycles, results and tags in order.
- Stream with out_ready low for 3 cycles mid-burst → in_ready low during the same cycles, held output unchanged, no beat lost or duplicated.
- With KS_SUB_EN defined, a=0x0005, b=0x0007, sub=1 → sum=0xFFFE, cout=0.
- Reset pulse while 3 beats are in flight → out_valid=0 immediately. After release, only newly accepted beats appear.
